// File: rtl/controlador_minero.sv
// Job controller for a hash miner: receives a 13-byte job, runs the miner, streams back a 7-byte result.
// Optional mining watchdog enabled by defining TIMEOUT_EN (limit set by MAX_CICLOS).
module controlador_minero #(
  parameter int MAX_CICLOS = 4096
) (
  input  logic        clk,
  input  logic        reset_L,
  input  logic [7:0]  in_dato,
  input  logic        in_valido,
  output logic        in_listo,
  output logic [95:0] payload,
  output logic [7:0]  target,
  output logic        active,
  input  logic        terminado,
  input  logic [31:0] nonceIn,
  input  logic [23:0] hashIn,
  output logic [7:0]  out_dato,
  output logic        out_valido,
  input  logic        out_listo,
  output logic        ocupado
);

  localparam logic [1:0] RECIBIR = 2'd0;
  localparam logic [1:0] MINAR   = 2'd1;
  localparam logic [1:0] ENVIAR  = 2'd2;

  if (MAX_CICLOS < 1) begin : g_param_chk
    $error("controlador_minero: MAX_CICLOS must be at least 1");
  end

  logic [1:0]  estado, estado_sig;
  logic [3:0]  cnt_in, cnt_out;
  logic [55:0] resultado;
  logic        in_xfer, out_xfer, fin_minado, expira;

  assign in_xfer    = in_valido && in_listo;
  assign out_xfer   = out_valido && out_listo;
  assign ocupado    = (estado == MINAR) || (estado == ENVIAR);
  assign out_valido = (estado == ENVIAR);

`ifdef TIMEOUT_EN
  localparam int TW = $clog2(MAX_CICLOS + 1);
  logic [TW-1:0] ciclos;

  assign expira = (ciclos == TW'(MAX_CICLOS - 1));

  // Watchdog counts cycles spent in MINAR; cleared everywhere else
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L)               ciclos <= '0;
    else if (estado == MINAR)   ciclos <= ciclos + 1'b1;
    else                        ciclos <= '0;
  end
`else
  assign expira = 1'b0;
`endif

  assign fin_minado = (estado == MINAR) && active && (terminado || expira);

  always_comb begin
    estado_sig = estado;
    case (estado)
      RECIBIR: if (in_xfer && cnt_in == 4'd12)  estado_sig = MINAR;
      MINAR:   if (fin_minado)                   estado_sig = ENVIAR;
      ENVIAR:  if (out_xfer && cnt_out == 4'd6)  estado_sig = RECIBIR;
      default:                                   estado_sig = RECIBIR;
    endcase
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      estado   <= RECIBIR;
      in_listo <= 1'b0;
    end else begin
      estado   <= estado_sig;
      // Registered so it stays low through reset and rises on the first edge after
      in_listo <= (estado_sig == RECIBIR);
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      cnt_in  <= '0;
      payload <= '0;
      target  <= '0;
    end else if (estado == RECIBIR && in_xfer) begin
      if (cnt_in == 4'd12) begin
        target <= in_dato;
        cnt_in <= '0;
      end else begin
        payload <= {payload[87:0], in_dato};
        cnt_in  <= cnt_in + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L)                                  active <= 1'b0;
    else if (estado == RECIBIR && in_xfer && cnt_in == 4'd12) active <= 1'b1;
    else if (fin_minado)                           active <= 1'b0;
  end

  // A real result wins over a simultaneous watchdog expiry
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L)        resultado <= '0;
    else if (fin_minado) resultado <= terminado ? {nonceIn, hashIn} : {56{1'b1}};
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L)                          cnt_out <= '0;
    else if (estado == ENVIAR && out_xfer) cnt_out <= (cnt_out == 4'd6) ? 4'd0 : cnt_out + 4'd1;
  end

  always_comb begin
    out_dato = 8'h00;
    if (estado == ENVIAR) begin
      case (cnt_out)
        4'd0:    out_dato = resultado[55:48];
        4'd1:    out_dato = resultado[47:40];
        4'd2:    out_dato = resultado[39:32];
        4'd3:    out_dato = resultado[31:24];
        4'd4:    out_dato = resultado[23:16];
        4'd5:    out_dato = resultado[15:8];
        4'd6:    out_dato = resultado[7:0];
        default: out_dato = 8'h00;
      endcase
    end
  end

endmodule

// File: tb/tb_controlador_minero.sv
// Scoreboard bench for controlador_minero; define TIMEOUT_EN to also exercise the watchdog (MAX_CICLOS=16).
module tb_controlador_minero;

`ifdef TIMEOUT_EN
  localparam int MC = 16;
`else
  localparam int MC = 4096;
`endif

  logic        clk = 1'b0;
  logic        reset_L = 1'b0;
  logic [7:0]  in_dato = '0;
  logic        in_valido = 1'b0;
  logic        in_listo;
  logic [95:0] payload;
  logic [7:0]  target;
  logic        active;
  logic        terminado = 1'b0;
  logic [31:0] nonceIn = '0;
  logic [23:0] hashIn = '0;
  logic [7:0]  out_dato;
  logic        out_valido;
  logic        out_listo = 1'b1;
  logic        ocupado;

  int checks = 0;
  int failures = 0;
  logic [7:0] sb_q[$];
  bit toggle_mode = 0;
  int tcnt = 0;
  bit prev_stall = 0;
  logic [7:0] prev_byte = '0;

  controlador_minero #(.MAX_CICLOS(MC)) dut (
    .clk(clk), .reset_L(reset_L), .in_dato(in_dato), .in_valido(in_valido),
    .in_listo(in_listo), .payload(payload), .target(target), .active(active),
    .terminado(terminado), .nonceIn(nonceIn), .hashIn(hashIn), .out_dato(out_dato),
    .out_valido(out_valido), .out_listo(out_listo), .ocupado(ocupado)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Downstream ready: always 1, or the 1,0,0 repeating pattern
  always @(posedge clk) begin
    #1;
    if (toggle_mode) begin
      out_listo = (tcnt % 3 == 0);
      tcnt++;
    end else begin
      out_listo = 1'b1;
    end
  end

  // Output monitor: pops the scoreboard on every accepted byte, checks holds during stalls
  always @(posedge clk) begin
    if (!reset_L) begin
      prev_stall = 0;
    end else begin
      if (prev_stall && out_valido) chk("hold", {88'h0, out_dato}, {88'h0, prev_byte});
      if (out_valido && out_listo) begin
        if (sb_q.size() == 0) chk("unexpected_out", {88'h0, out_dato}, 96'hDEAD);
        else chk("out_byte", {88'h0, out_dato}, {88'h0, sb_q.pop_front()});
      end
      prev_stall = out_valido && !out_listo;
      prev_byte  = out_dato;
    end
  end

  task automatic send_job(input logic [7:0] b[13]);
    for (int i = 0; i < 13; i++) begin
      int guard = 0;
      in_dato   = b[i];
      in_valido = 1'b1;
      while (!in_listo && guard < 100) begin
        @(posedge clk); #1; guard++;
      end
      if (guard >= 100) chk("in_listo_timeout", 96'h0, 96'h1);
      @(posedge clk); #1;
    end
    in_valido = 1'b0;
  endtask

  task automatic push_result(input logic [31:0] n, input logic [23:0] h);
    logic [55:0] r;
    r = {n, h};
    for (int i = 6; i >= 0; i--) sb_q.push_back(r[8*i +: 8]);
  endtask

  // Miner model: done pulse after n cycles of active
  task automatic mine(input int n, input logic [31:0] nonce, input logic [23:0] hash);
    push_result(nonce, hash);
    repeat (n - 1) @(posedge clk);
    #1;
    chk("ocupado_minar", {95'h0, ocupado}, 96'h1);
    terminado = 1'b1; nonceIn = nonce; hashIn = hash;
    @(posedge clk); #1;
    terminado = 1'b0; nonceIn = '0; hashIn = '0;
    chk("active_drop", {95'h0, active}, 96'h0);
    chk("out_valido_rise", {95'h0, out_valido}, 96'h1);
  endtask

  task automatic wait_idle(input string tag);
    int guard = 0;
    while (!(in_listo && sb_q.size() == 0) && guard < 300) begin
      @(posedge clk); #1; guard++;
    end
    chk(tag, {64'h0, sb_q.size(), 1'b0}, 96'h0);
    chk({tag, "_in_listo"}, {95'h0, in_listo}, 96'h1);
    chk({tag, "_out_valido"}, {95'h0, out_valido}, 96'h0);
  endtask

  logic [7:0] job1[13] = '{8'h39, 8'h7d, 8'h9f, 8'h2f, 8'h40, 8'hca, 8'h9e,
                           8'h6c, 8'h6b, 8'h1f, 8'h33, 8'h24, 8'h0a};
  logic [7:0] job2[13] = '{8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hab, 8'hcd,
                           8'hef, 8'hfe, 8'hdc, 8'hba, 8'h98, 8'h77};

  initial begin
    #2;
    chk("rst_in_listo", {95'h0, in_listo}, 96'h0);
    chk("rst_active", {95'h0, active}, 96'h0);
    chk("rst_out_valido", {95'h0, out_valido}, 96'h0);
    chk("rst_ocupado", {95'h0, ocupado}, 96'h0);
    chk("rst_out_dato", {88'h0, out_dato}, 96'h0);
    chk("rst_payload", payload, 96'h0);
    chk("rst_target", {88'h0, target}, 96'h0);
    @(posedge clk); #1;
    reset_L = 1'b1;
    @(posedge clk); #1;
    chk("in_listo_after_rst", {95'h0, in_listo}, 96'h1);

    // Scenarios 1 and 2: decode job, 20-cycle miner, full-rate output
    send_job(job1);
    chk("s1_payload", payload, 96'h397d9f2f40ca9e6c6b1f3324);
    chk("s1_target", {88'h0, target}, 96'h0a);
    chk("s1_active", {95'h0, active}, 96'h1);
    chk("s1_in_listo", {95'h0, in_listo}, 96'h0);
    mine(20, 32'h0000_1A2B, 24'h05_C3D1);
    wait_idle("s2_drain");

    // Scenario 3: stalled output
    send_job(job2);
    chk("s3_payload", payload, 96'h0123456789abcdeffedcba98);
    chk("s3_target", {88'h0, target}, 96'h77);
    toggle_mode = 1; tcnt = 0;
    mine(5, 32'hDEAD_BEEF, 24'h12_3456);
    wait_idle("s3_drain");
    toggle_mode = 0;

    // Scenario 4: reset after 6 bytes discards the partial job
    for (int i = 0; i < 6; i++) begin
      in_dato = job2[i]; in_valido = 1'b1;
      @(posedge clk); #1;
    end
    in_valido = 1'b0;
    #2 reset_L = 1'b0;
    #1;
    chk("s4_active", {95'h0, active}, 96'h0);
    chk("s4_in_listo", {95'h0, in_listo}, 96'h0);
    chk("s4_payload", payload, 96'h0);
    @(posedge clk); #1;
    reset_L = 1'b1;
    @(posedge clk); #1;
    send_job(job1);
    chk("s4_payload2", payload, 96'h397d9f2f40ca9e6c6b1f3324);
    chk("s4_target2", {88'h0, target}, 96'h0a);
    mine(3, 32'h8000_0001, 24'hFF_0001);
    wait_idle("s4_drain");

    // Scenario 5: terminado while receiving is ignored
    terminado = 1'b1; nonceIn = 32'h1111_1111; hashIn = 24'h22_2222;
    repeat (4) @(posedge clk);
    #1;
    terminado = 1'b0;
    chk("s5_in_listo", {95'h0, in_listo}, 96'h1);
    chk("s5_active", {95'h0, active}, 96'h0);
    chk("s5_ocupado", {95'h0, ocupado}, 96'h0);
    chk("s5_out_valido", {95'h0, out_valido}, 96'h0);

    // Reset mid-result: nothing must come out afterwards
    send_job(job2);
    mine(2, 32'hCAFE_0000, 24'h00_BEEF);
    @(posedge clk); #1;
    sb_q.delete();
    reset_L = 1'b0;
    #1;
    chk("rst_mid_out_valido", {95'h0, out_valido}, 96'h0);
    @(posedge clk); #1;
    reset_L = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("rst_mid_idle", {95'h0, in_listo}, 96'h1);

`ifdef TIMEOUT_EN
    // Scenario 6: watchdog expiry yields all-FF result
    begin
      int act_cycles = 0;
      send_job(job1);
      push_result(32'hFFFF_FFFF, 24'hFF_FFFF);
      while (active && act_cycles < 100) begin
        @(posedge clk); #1; act_cycles++;
      end
      chk("s6_active_cycles", act_cycles, MC);
      wait_idle("s6_drain");
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/controlador_minero.md
CONTROLADOR_MINERO -- requirements
Module: controlador_minero

Interface
REQ-001 Parameter: MAX_CICLOS, default 4096, mining watchdog limit in clock cycles; used only when TIMEOUT_EN is defined.
REQ-002 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: reset_L  input  1  reset, asynchronous, active-low.
REQ-004 Port: in_dato  input  8  inbound job byte.
REQ-005 Port: in_valido  input  1  in_dato is valid.
REQ-006 Port: in_listo  output  1  block accepts in_dato this cycle.
REQ-007 Port: payload  output  96  job payload driven to the miner.
REQ-008 Port: target  output  8  difficulty target driven to the miner.
REQ-009 Port: active  output  1  miner enable.
REQ-010 Port: terminado  input  1  miner done flag.
REQ-011 Port: nonceIn  input  32  miner result nonce.
REQ-012 Port: hashIn  input  24  miner result hash.
REQ-013 Port: out_dato  output  8  outbound result byte.
REQ-014 Port: out_valido  output  1  out_dato is valid.
REQ-015 Port: out_listo  input  1  downstream accepts out_dato.
REQ-016 Port: ocupado  output  1  high in MINAR and ENVIAR.

Function
REQ-017 States: RECIBIR, MINAR, ENVIAR; the block shall leave reset in RECIBIR.
REQ-018 In RECIBIR, in_listo shall be 1; a byte transfers on any cycle with in_valido and in_listo both high.
REQ-019 The block shall receive 13 bytes per job: 12 payload bytes, MSB first, into payload[95:88] down to [7:0], then 1 target byte.
REQ-020 On transfer of the 13th byte, the next state shall be MINAR and active shall be 1 from the following cycle.
REQ-021 In MINAR, in_listo shall be 0, and payload and target shall hold stable.
REQ-022 In MINAR, when terminado is 1 while active is 1, the block shall register nonceIn and hashIn that cycle.
REQ-023 In that same terminado case, active shall drop to 0 the next cycle and the state shall move to ENVIAR.
REQ-024 terminado shall be ignored outside MINAR.
REQ-025 ENVIAR shall emit 7 bytes: nonce MSB first (4 bytes), then hash MSB first (3 bytes).
REQ-026 In ENVIAR, out_valido shall be 1, and out_dato shall hold stable until a cycle where out_listo is 1.
REQ-027 Byte advance in ENVIAR shall occur only on cycles where out_valido and out_listo are both 1; back-to-back acceptance gives 1 byte per cycle.
REQ-028 After the 7th byte is accepted, out_valido shall drop the next cycle and the state shall return to RECIBIR with the byte counter at 0.
REQ-029 Minimum latency from 13th input byte to 1st output byte valid shall be miner time plus 2 cycles.
REQ-030 Byte counters shall be 4 bits and never exceed 12 (input) or 6 (output).

Reset
REQ-031 While reset_L is 0, all outputs and state shall take reset values immediately, without waiting for a clock edge.
REQ-032 Reset values: state RECIBIR, counters 0, payload 0, target 0, active 0, in_listo 0, out_valido 0, out_dato 0, ocupado 0.
REQ-033 in_listo shall rise on the first clk edge after reset_L returns to 1.
REQ-034 Reset mid-job (any state) shall discard the partial job or result with no bytes emitted.

Configuration
REQ-035 Macro TIMEOUT_EN shall control the mining watchdog.
REQ-036 With TIMEOUT_EN defined, a counter shall run during MINAR.
REQ-037 With TIMEOUT_EN defined, reaching MAX_CICLOS without terminado shall drop active and enter ENVIAR with all 7 bytes equal to 8'hFF.
REQ-038 With TIMEOUT_EN defined, terminado in the same cycle as the timeout shall take priority and report the real result.
REQ-039 Without TIMEOUT_EN, the block shall have no counter and MINAR waits indefinitely.

Verification
REQ-040 Scenario 1: bytes 39 7d 9f 2f 40 ca 9e 6c 6b 1f 33 24 0a -> payload=96'h397d9f2f40ca9e6c6b1f3324, target=8'h0a, active=1 next cycle.
REQ-041 Scenario 2: model miner asserts terminado after 20 cycles with nonce 32'h0000_1A2B, hash 24'h05_C3D1; out_listo=1 -> out bytes 00 00 1A 2B 05 C3 D1, then in_listo=1.
REQ-042 Scenario 3: out_listo toggles 1,0,0,1,... -> every byte held while out_listo=0; none dropped or duplicated; still 7 bytes.
REQ-043 Scenario 4: reset_L pulsed low after 6 input bytes -> active=0 immediately; then a fresh 13-byte job decodes correctly.
REQ-044 Scenario 5: terminado=1 during RECIBIR -> no state change, no output.
REQ-045 Scenario 6 (TIMEOUT_EN, MAX_CICLOS=16): no terminado -> active drops after 16 cycles, 7 bytes FF emitted.
